// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with frame-aligned
// display updates, dead-time between digits and leading-zero suppression.
module disp_scan_ctrl #(
    parameter int unsigned DIGIT_TICKS = 50000,
    parameter int unsigned DEAD_TICKS  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic        blank_i,
    output logic        ack_o,
    output logic        frame_o,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic [2:0]  idx_o
);

    localparam int unsigned TICK_W = $clog2(DIGIT_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_DEAD = TICK_W'(DEAD_TICKS);
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Scan position
    logic [TICK_W-1:0] tick, tick_n;
    logic [2:0]        idx, idx_n;

    // Display and pending-load registers
    logic [31:0]       disp, disp_n;
    logic [31:0]       pdata, pdata_n;
    logic              pend, pend_n;

    // Registered output next values
    logic              ack_n, frame_n;
    logic [7:0]        an_n;
    logic [6:0]        seg_n;

    logic              frame_end_c;
    logic [3:0]        nib_c;
    logic [7:0]        upper_zero_c;
    logic              blank_c;

    // Active-low seven-segment encoding, bit0 = a ... bit6 = g
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign frame_end_c = (idx == 3'd7) && (tick == TICK_LAST);
    assign nib_c       = disp[{idx, 2'b00} +: 4];

    // upper_zero_c[k]: nibbles k..7 of the display register are all zero
    always_comb begin
        upper_zero_c    = '0;
        upper_zero_c[7] = (disp[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            upper_zero_c[k] = upper_zero_c[k+1] && (disp[4*k +: 4] == 4'h0);
        end
    end

    assign blank_c = blank_i && (idx != 3'd0) && upper_zero_c[idx];

    // Next-state and next-output logic
    always_comb begin
        tick_n  = tick + TICK_W'(1);
        idx_n   = idx;
        disp_n  = disp;
        pdata_n = pdata;
        pend_n  = pend;
        ack_n   = 1'b0;
        frame_n = 1'b0;
        an_n    = AN_OFF;
        seg_n   = SEG_OFF;

        if (tick == TICK_LAST) begin
            tick_n = '0;
            idx_n  = idx + 3'd1;
        end

        if (load_i) begin
            pdata_n = data_i;
            pend_n  = 1'b1;
        end

        // Display only changes on the frame boundary; a same-cycle load bypasses pending
        if (frame_end_c) begin
            frame_n = 1'b1;
            if (load_i) begin
                disp_n = data_i;
                pend_n = 1'b0;
                ack_n  = 1'b1;
            end else if (pend) begin
                disp_n = pdata;
                pend_n = 1'b0;
                ack_n  = 1'b1;
            end
        end

        if (tick >= TICK_DEAD) begin
            an_n  = ~(8'b1 << idx);
            seg_n = blank_c ? SEG_OFF : hex_seg(nib_c);
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick    <= '0;
            idx     <= '0;
            disp    <= '0;
            pdata   <= '0;
            pend    <= 1'b0;
            ack_o   <= 1'b0;
            frame_o <= 1'b0;
            an_o    <= AN_OFF;
            seg_o   <= SEG_OFF;
        end else begin
            tick    <= tick_n;
            idx     <= idx_n;
            disp    <= disp_n;
            pdata   <= pdata_n;
            pend    <= pend_n;
            ack_o   <= ack_n;
            frame_o <= frame_n;
            an_o    <= an_n;
            seg_o   <= seg_n;
        end
    end

    assign idx_o = idx;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a cycle-count based reference model.
module tb_disp_scan_ctrl;

    localparam int DT   = 4;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        load_i = 1'b0;
    logic        blank_i = 1'b0;
    logic        ack_o, frame_o;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic [2:0]  idx_o;

    disp_scan_ctrl #(.DIGIT_TICKS(DT), .DEAD_TICKS(DEAD)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .load_i  (load_i),
        .blank_i (blank_i),
        .ack_o   (ack_o),
        .frame_o (frame_o),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .idx_o   (idx_o)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk  = 0;
    int n_pass = 0;

    // Model: scan position derived from cycles since reset
    int          m_cnt = 0;
    logic [31:0] m_disp = '0;
    logic [31:0] m_pdata = '0;
    bit          m_pend = 1'b0;
    bit          cur_blank = 1'b0;

    int          ack_cnt = 0;
    int          frame_cnt = 0;
    logic [6:0]  seg_obs [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 8; k++) seg_obs[k] = 7'h55;
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [31:0] d, input bit bl);
        int          tk, ix;
        bit          fe;
        logic        e_ack, e_frame;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic [2:0]  e_idx;
        logic [31:0] upper;
        @(negedge clk);
        rst_i = r; load_i = ld; data_i = d; blank_i = bl;
        if (r) begin
            e_ack = 0; e_frame = 0; e_an = 8'hFF; e_seg = 7'h7F; e_idx = 0;
            m_cnt = 0; m_disp = 0; m_pdata = 0; m_pend = 0;
        end else begin
            tk = m_cnt % DT;
            ix = (m_cnt / DT) % 8;
            fe = (ix == 7) && (tk == DT - 1);
            e_frame = fe;
            e_ack   = fe && (ld || m_pend);
            upper   = m_disp >> (4 * ix);
            if (tk < DEAD) begin
                e_an = 8'hFF; e_seg = 7'h7F;
            end else begin
                e_an = ~(8'(1) << ix);
                if (bl && ix > 0 && upper == 0) e_seg = 7'h7F;
                else e_seg = seg_tab[upper[3:0]];
            end
            if (ld) begin m_pdata = d; m_pend = 1; end
            if (fe && m_pend) begin m_disp = m_pdata; m_pend = 0; end
            m_cnt++;
            e_idx = 3'((m_cnt / DT) % 8);
        end
        @(posedge clk);
        #1;
        chk("ack", 32'(ack_o), 32'(e_ack));
        chk("frame", 32'(frame_o), 32'(e_frame));
        chk("an", 32'(an_o), 32'(e_an));
        chk("seg", 32'(seg_o), 32'(e_seg));
        chk("idx", 32'(idx_o), 32'(e_idx));
        if (ack_o === 1'b1) ack_cnt++;
        if (frame_o === 1'b1) frame_cnt++;
        for (int k = 0; k < 8; k++)
            if (an_o === ~(8'(1) << k)) seg_obs[k] = seg_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, cur_blank);
    endtask

    task automatic run_to(input int c);
        while (m_cnt < c) cyc(0, 0, 32'h0, cur_blank);
    endtask

    initial begin
        // Reset then idle: two frames of zeros
        cyc(1, 0, 0, 0);
        cyc(1, 1, 32'hFFFF_FFFF, 0);
        ack_cnt = 0; frame_cnt = 0; clear_obs();
        idle(64);
        chk("idle_acks", 32'(ack_cnt), 0);
        chk("idle_frames", 32'(frame_cnt), 2);
        chk("idle_seg0", 32'(seg_obs[0]), 32'h40);
        chk("idle_seg7", 32'(seg_obs[7]), 32'h40);

        // Load at cycle 5, shown from the next frame
        cyc(1, 0, 0, 0);
        ack_cnt = 0;
        run_to(5);
        cyc(0, 1, 32'h89AB_CDEF, 0);
        run_to(32);
        chk("load_ack", 32'(ack_cnt), 1);
        clear_obs();
        run_to(64);
        chk("load_seg0", 32'(seg_obs[0]), 32'h0E);
        chk("load_seg1", 32'(seg_obs[1]), 32'h06);
        chk("load_seg7", 32'(seg_obs[7]), 32'h00);

        // Two loads in one frame: latest wins, single ack
        cyc(1, 0, 0, 0);
        ack_cnt = 0;
        run_to(3);
        cyc(0, 1, 32'h1, 0);
        run_to(10);
        cyc(0, 1, 32'h2, 0);
        run_to(32);
        clear_obs();
        run_to(64);
        chk("two_acks", 32'(ack_cnt), 1);
        chk("two_seg0", 32'(seg_obs[0]), 32'h24);

        // Load on the frame-end cycle bypasses pending
        ack_cnt = 0;
        run_to(95);
        cyc(0, 1, 32'h30, 0);
        chk("fe_ack", 32'(ack_o), 1);
        clear_obs();
        run_to(128);
        chk("fe_acks", 32'(ack_cnt), 1);
        chk("fe_seg0", 32'(seg_obs[0]), 32'h40);
        chk("fe_seg1", 32'(seg_obs[1]), 32'h30);
        chk("fe_seg2", 32'(seg_obs[2]), 32'h40);

        // Leading-zero suppression
        cur_blank = 1;
        clear_obs();
        run_to(160);
        chk("blk_seg0", 32'(seg_obs[0]), 32'h40);
        chk("blk_seg1", 32'(seg_obs[1]), 32'h30);
        for (int k = 2; k < 8; k++) chk("blk_segk", 32'(seg_obs[k]), 32'h7F);
        cur_blank = 0;

        // Reset mid-frame with a pending load
        run_to(170);
        cyc(0, 1, 32'hDEAD_BEEF, 0);
        run_to(178);
        cyc(1, 0, 0, 0);
        chk("rst_an", 32'(an_o), 32'hFF);
        chk("rst_idx", 32'(idx_o), 0);
        ack_cnt = 0; clear_obs();
        run_to(64);
        chk("rst_acks", 32'(ack_cnt), 0);
        chk("rst_seg0", 32'(seg_obs[0]), 32'h40);
        chk("rst_seg5", 32'(seg_obs[5]), 32'h40);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, ld;
            logic [31:0] d;
            r  = ($urandom_range(0, 599) == 0);
            ld = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = $urandom & 32'h0000_00FF;
                2: d = $urandom & 32'h000F_F000;
                default: d = 32'h0;
            endcase
            if ($urandom_range(0, 49) == 0) cur_blank = ~cur_blank;
            cyc(r, ld, d, cur_blank);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 50000, meaning clk_i cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter DEAD_TICKS, default 2, meaning cycles at the start of each slot with all anodes off (legal range 1..DIGIT_TICKS-2).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port data_i, input, 32 bits: value to display, 8 hex nibbles, nibble k on digit k.
REQ-006 SHALL have port load_i, input, 1 bit: capture request for data_i.
REQ-007 SHALL have port blank_i, input, 1 bit: leading-zero suppression enable.
REQ-008 SHALL have port ack_o, output, 1 bit: one-cycle pulse when pending data enters the display register.
REQ-009 SHALL have port frame_o, output, 1 bit: one-cycle pulse at the end of each 8-digit frame.
REQ-010 SHALL have port an_o, output, 8 bits: active-low digit enables, bit k = digit k.
REQ-011 SHALL have port seg_o, output, 7 bits: active-low segments, bit0=a ... bit6=g.
REQ-012 SHALL have port idx_o, output, 3 bits: current digit index.

Function
REQ-013 SHALL keep a tick counter 0..DIGIT_TICKS-1, incrementing every cycle and wrapping to 0 after DIGIT_TICKS-1.
REQ-014 SHALL advance the digit index idx (0..7) when tick==DIGIT_TICKS-1, wrapping from 7 to 0.
REQ-015 SHALL drive idx_o directly from idx.
REQ-016 SHALL define frame end as idx==7 and tick==DIGIT_TICKS-1.
REQ-017 SHALL assert frame_o in the cycle after frame end, for exactly one cycle.
REQ-018 SHALL latch data_i into a pending register and set pending=1 on any cycle with load_i=1; a later load_i overwrites it, so the latest data wins.
REQ-019 SHALL copy the pending data into the 32-bit display register at frame end when pending=1, clear pending, and pulse ack_o in the next cycle.
REQ-020 SHALL, when load_i=1 on the frame-end cycle, capture that cycle's data_i directly into the display register (bypass) and pulse ack_o in the next cycle.
REQ-021 SHALL never change the display register mid-frame.
REQ-022 SHALL register an_o and seg_o, so their value in cycle t+1 reflects the tick, idx and display register of cycle t (one-cycle latency).
REQ-023 SHALL drive an_o=8'hFF and seg_o=7'h7F when tick<DEAD_TICKS (dead window).
REQ-024 SHALL otherwise drive an_o with only bit idx low, and seg_o with the encoding of nibble idx of the display register.
REQ-025 SHALL encode 0..F as 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-026 SHALL, when blank_i=1, blank digit k (k>=1) if nibbles k..7 of the display register are all zero; a blanked digit gets seg_o=7'h7F while its an_o bit is still driven low.
REQ-027 SHALL never blank digit 0.
REQ-028 SHALL sample blank_i combinationally into the registered output, with no frame alignment.

Reset
REQ-029 SHALL, when rst_i=1 at a clock edge, set tick=0, idx=0, display register=0, pending register=0 and pending=0, regardless of any scan in progress.
REQ-030 SHALL, on that same reset edge, set ack_o=0, frame_o=0, an_o=8'hFF, seg_o=7'h7F and idx_o=0.
REQ-031 SHALL discard any pending load on reset; load_i is ignored while rst_i=1.
REQ-032 SHALL resume scanning at tick=0, idx=0 on the first cycle after rst_i falls.

Verification (DIGIT_TICKS=4, DEAD_TICKS=1, frame = 32 cycles)
REQ-033 SHALL cover reset then idle with blank_i=0 -> an_o=FF for 1 cycle then FE for 3 cycles per slot, walking through FD..7F; seg_o=40 when an_o is not FF; frame_o pulses every 32 cycles.
REQ-034 SHALL cover load_i with data_i=32'h89ABCDEF at cycle 5 -> ack_o only in the cycle after the first frame end; the next frame shows digit0 seg 0E, digit1 06, digit7 00.
REQ-035 SHALL cover two loads in one frame (32'h1, then 32'h2) -> a single ack_o; the display shows 2 (seg 24 on digit 0).
REQ-036 SHALL cover load_i on the frame-end cycle with 32'h00000030 -> ack_o in the next cycle; the next frame has digit1 seg 30.
REQ-037 SHALL cover blank_i=1 with display 32'h00000030 -> digits 2..7 seg 7F with their anodes active, digit1 seg 30, digit0 seg 40.
REQ-038 SHALL cover rst_i asserted mid-frame with a load pending -> the next cycle has an_o=FF and idx_o=0; no ack_o follows; the display register stays 0.
